// File: rtl/attack_issue_ctrl.sv
// -----------------------------------------------------------------------------
// attack_issue_ctrl
//
// Player-side front end of the attack path. It synchronizes and debounces the
// raw active-low attack button and latches the one-hot row switches and the
// 3-bit mode switches. For each press it issues one fixed-length active-low
// attack strobe, with stable selection lines, followed by a release debounce
// and a cooldown before the next press is accepted.
//
// Optional feature (macro ATTACK_COUNT_EN): adds saturating attack and error
// counters as extra outputs. With the macro undefined neither port nor any
// counter logic exists.
//
// Ports:
//   clk        in   system clock, all logic on the rising edge
//   rst_n      in   synchronous reset, active low
//   btn_n      in   raw attack button, active low, asynchronous to clk
//   row_sw     in   [2:0] raw row switches {D,C,B}, must be one-hot
//   mode_sw    in   [2:0] raw mode switches {E,F,G}
//   atk_n      out  registered attack strobe, active low
//   atk_row    out  [2:0] latched one-hot row, valid while atk_n = 0
//   atk_mode   out  [2:0] latched mode, valid while atk_n = 0
//   busy       out  high whenever the FSM is not idle
//   err        out  one-cycle pulse on a rejected selection
//   atk_count  out  [7:0] saturating count of strobes   (ATTACK_COUNT_EN)
//   err_count  out  [3:0] saturating count of err pulses (ATTACK_COUNT_EN)
// -----------------------------------------------------------------------------
module attack_issue_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 4,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    input  logic [2:0] row_sw,
    input  logic [2:0] mode_sw,
    output logic       atk_n,
    output logic [2:0] atk_row,
    output logic [2:0] atk_mode,
    output logic       busy,
    output logic       err
`ifdef ATTACK_COUNT_EN
    ,
    output logic [7:0] atk_count,
    output logic [3:0] err_count
`endif
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        DEB  = 3'd1,
        FIRE = 3'd2,
        WREL = 3'd3,
        COOL = 3'd4
    } state_t;

    // Terminal counts: the shared counter starts at 0 on every state entry,
    // so a phase of N cycles ends when the counter reads N-1.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             atk_n_q;
    logic [2:0]       atk_row_q;
    logic [2:0]       atk_mode_q;
    logic             err_q;

    logic             btn_s;
    logic             row_ok;
    logic             mode_ok;
    logic             deb_done;
    logic             fire_go;
    logic             reject_go;

    assign btn_s = sync2_q;

    // 2-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk) begin
        // NOTE: the synchronizer resets to 1, the released level of an
        // active-low button, so reset never looks like a press.
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
        end
    end

    // Selection validity, evaluated on the raw switches at the latch edge.
    always_comb begin
        row_ok  = 1'b0;
        mode_ok = 1'b0;
        case (row_sw)
            3'b001, 3'b010, 3'b100: row_ok = 1'b1;
            default:                row_ok = 1'b0;
        endcase
        case (mode_sw)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: mode_ok = 1'b1;
            default:                                mode_ok = 1'b0;
        endcase
    end

    // Debounce completes on the edge that sees the last required low sample.
    assign deb_done  = (state_q == DEB) && !btn_s && (cnt_q == DEB_LAST);
    assign fire_go   = deb_done && row_ok && mode_ok;
    assign reject_go = deb_done && !(row_ok && mode_ok);

    // Main FSM with registered strobe and selection outputs.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            atk_n_q    <= 1'b1;
            atk_row_q  <= 3'b000;
            atk_mode_q <= 3'b000;
            err_q      <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!btn_s) begin
                        state_q <= DEB;
                        cnt_q   <= '0;
                    end
                end

                DEB: begin
                    if (btn_s) begin
                        // Bounce: any high sample aborts the press.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (fire_go) begin
                        state_q    <= FIRE;
                        cnt_q      <= '0;
                        atk_n_q    <= 1'b0;
                        atk_row_q  <= row_sw;
                        atk_mode_q <= mode_sw;
                    end else if (reject_go) begin
                        state_q <= WREL;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                FIRE: begin
                    // The button is not looked at here: the strobe length is
                    // fixed regardless of an early release.
                    if (cnt_q == HOLD_LAST) begin
                        state_q    <= WREL;
                        cnt_q      <= '0;
                        atk_n_q    <= 1'b1;
                        atk_row_q  <= 3'b000;
                        atk_mode_q <= 3'b000;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                WREL: begin
                    // Holding the button parks here, giving one strobe per press.
                    if (!btn_s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= COOL;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                COOL: begin
                    if (cnt_q == COOL_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign atk_n    = atk_n_q;
    assign atk_row  = atk_row_q;
    assign atk_mode = atk_mode_q;
    assign err      = err_q;
    assign busy     = (state_q != IDLE);

`ifdef ATTACK_COUNT_EN
    logic [7:0] atk_count_q;
    logic [3:0] err_count_q;

    // Saturating event counters; they advance on the same edge that starts
    // the strobe or raises err.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            atk_count_q <= 8'd0;
            err_count_q <= 4'd0;
        end else begin
            if (fire_go && (atk_count_q != 8'hFF)) begin
                atk_count_q <= atk_count_q + 8'd1;
            end
            if (reject_go && (err_count_q != 4'hF)) begin
                err_count_q <= err_count_q + 4'd1;
            end
        end
    end

    assign atk_count = atk_count_q;
    assign err_count = err_count_q;
`endif

endmodule

// File: doc/attack_issue_ctrl.md
Name: attack_issue_ctrl

Overview:
- Front end of the attack path: the player-side controller that generates the active-low attack button and the selection/mode lines consumed by the attack-enable decoder.
- Synchronizes and debounces the raw active-low button, then latches the row switches (one-hot) and the 3-bit mode switches.
- Validates the selection and issues one clean, fixed-length, active-low attack strobe per press, with stable selection lines and a cooldown before the next attack.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles required on press and on release (>=2)
HOLD_CYCLES, 4, cycles atk_n is held low per attack (>=1)
COOLDOWN_CYCLES, 8, dead cycles after release before a new press is accepted (>=1)
CNT_W, 8, width of the shared internal counter; must hold max(DEBOUNCE, HOLD, COOLDOWN)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous reset, active low
btn_n  in  1  raw attack button, active low, asynchronous to clk
row_sw  in  3  raw row selection switches {D,C,B}; must be one-hot
mode_sw  in  3  raw mode switches {E,F,G}
atk_n  out  1  registered attack strobe to decoder, active low
atk_row  out  3  latched one-hot row {D,C,B}; valid while atk_n=0
atk_mode  out  3  latched mode {E,F,G}; valid while atk_n=0
busy  out  1  high whenever the FSM is not in IDLE
err  out  1  one-cycle pulse when a rejected selection is detected

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, counter=0, synchronizer flops=1, atk_n=1, atk_row=000, atk_mode=000, busy=0, err=0. Reset overrides any state, including mid-FIRE; atk_n returns high on that same edge.
- btn_n passes through a 2-flop synchronizer; its output is btn_s. row_sw and mode_sw are sampled directly at the latch edge. They must be stable by then.
- Valid mode: {E,F,G} in {001,010,011,100,101}. Invalid mode: 000, 110, 111. Valid row: exactly one bit set.
- FSM states:
  - IDLE: btn_s=0 -> DEB, counter=0.
  - DEB: btn_s=1 -> IDLE (bounce rejected). While btn_s=0, counter increments each cycle. When counter==DEBOUNCE_CYCLES-1 and btn_s=0, latch row_sw and mode_sw, then:
    - both valid -> FIRE: atk_n=0, atk_row and atk_mode driven from the latch, counter=0.
    - either invalid -> WREL: err=1 for exactly one cycle, atk_n stays 1.
  - FIRE: atk_n=0 for exactly HOLD_CYCLES cycles, with atk_row and atk_mode stable. Releasing the button early does not shorten the strobe. At the end: atk_n=1, atk_row=000, atk_mode=000, then -> WREL with counter=0.
  - WREL: needs DEBOUNCE_CYCLES consecutive cycles with btn_s=1; any btn_s=0 resets the counter. When complete -> COOL.
  - COOL: COOLDOWN_CYCLES cycles; btn_s is ignored. Then -> IDLE.
- Outside FIRE: atk_n=1, atk_row=000, atk_mode=000.
- Latency: let edge 0 be the first edge sampling btn_n=0, with btn_n held low. btn_s=0 after edge 1, DEB entered at edge 2, atk_n falls at edge DEBOUNCE_CYCLES+2 and rises at edge DEBOUNCE_CYCLES+2+HOLD_CYCLES.
- One attack per press: holding the button indefinitely produces exactly one strobe.
- busy is combinational from state (state!=IDLE). err is registered.

Optional Feature:
- Macro: ATTACK_COUNT_EN.
- Defined:
  - Adds output atk_count[7:0], reset to 0.
  - Increments by 1 on each FIRE entry and saturates at 255.
  - Adds output err_count[3:0], reset to 0; increments on each err pulse and saturates at 15.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with btn_n=0 -> atk_n=1, atk_row=000, atk_mode=000, busy=0, err=0; after release an attack proceeds normally.
- Clean press: defaults, row_sw=001, mode_sw=010, btn_n low for 40 cycles from edge 0 -> atk_n low on edges 18..21 with atk_row=001, atk_mode=010 throughout; exactly one strobe; busy=1 from edge 2.
- Bounce: btn_n low 5 cycles, high 1 cycle, repeated 3 times, then high -> no atk_n pulse, FSM back in IDLE, busy=0.
- Invalid selection: row_sw=011 with mode_sw=010, and separately row_sw=100 with mode_sw=110 -> err=1 for one cycle at edge 18, atk_n stays 1.
- Reset mid-FIRE: assert rst_n=0 at edge 19 -> atk_n=1 and busy=0 at that edge; a new press after reset issues a full 4-cycle strobe.
- Cooldown/repeat: second press 2 cycles after release debounce completes is ignored until COOL ends; a press held through COOL fires once after the IDLE->DEB->FIRE latency. With ATTACK_COUNT_EN, two valid presses -> atk_count=2, err_count=0.
